// File: rtl/lvds_rx_decoder.sv
// lvds_rx_decoder: word aligner and pixel decoder for a 4-lane 7:1 LVDS link.
// The clock lane is searched for the 1100011 pattern across the seven bit
// offsets of a {prev,curr} word pair. Once aligned, the three data lanes are
// unpacked into sync/enable and 8-bit colour.
// Optional line/frame measurement is built only when LVDS_RX_TIMING_EN is
// defined. Otherwise ActiveWidth/ActiveHeight are tied to zero.
//
// Handshake: there is none. Every lane delivers one word per clk and the
// decoded pixel leaves three cycles later, with no back-pressure.
module lvds_rx_decoder #(
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  clock_word,
  input  logic [6:0]  channel1_word,
  input  logic [6:0]  channel2_word,
  input  logic [6:0]  channel3_word,
  output logic        HSync,
  output logic        VSync,
  output logic        DataEnable,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        locked,
  output logic [2:0]  slip,
  output logic [10:0] ActiveWidth,
  output logic [10:0] ActiveHeight
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [6:0] CLK_PATTERN = 7'b1100011;

  localparam int CW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int MW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;

  // Lane 0 is the clock lane. Lanes 1..3 carry pixel data.
  logic [3:0][6:0] cur_q, cur_d;
  logic [3:0][6:0] prv_q, prv_d;
  logic [3:0][6:0] algn;

  logic [1:0]    state_q, state_d;
  logic [2:0]    slip_q, slip_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          locked_q, locked_d;
  logic [1:0]    lkp_q, lkp_d;

  logic [20:0] dat_q, dat_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic [7:0]  red_q, red_d;
  logic [7:0]  grn_q, grn_d;
  logic [7:0]  blu_q, blu_d;

  logic          clk_match;
  logic [2:0]    slip_inc;
  logic [CW-1:0] cnt_inc;
  logic [MW-1:0] miss_inc;
  logic          data_ok;

  // Window starting s bits after the MSB of prev; s = 0 returns prev itself.
  function automatic logic [6:0] align_word(input logic [6:0] prv,
                                            input logic [6:0] cur,
                                            input logic [2:0] s);
    logic [13:0] v;
    v = {prv, cur} << s;
    return v[13:7];
  endfunction

  // Input capture: current word per lane plus the one before it.
  always_comb begin
    cur_d = {channel3_word, channel2_word, channel1_word, clock_word};
    prv_d = cur_q;
  end

  // Apply the shared slip offset to every lane.
  always_comb begin
    algn = '0;
    for (int l = 0; l < 4; l++) begin
      algn[l] = align_word(prv_q[l], cur_q[l], slip_q);
    end
  end

  // Alignment FSM: SEARCH walks slip, CHECK confirms, LOCKED tolerates short bursts.
  always_comb begin
    clk_match = (algn[0] == CLK_PATTERN);
    slip_inc  = (slip_q == 3'd6) ? 3'd0 : slip_q + 3'd1;
    cnt_inc   = cnt_q + 1'b1;
    miss_inc  = miss_q + 1'b1;
    state_d   = state_q;
    slip_d    = slip_q;
    cnt_d     = cnt_q;
    miss_d    = miss_q;
    locked_d  = locked_q;
    case (state_q)
      S_SEARCH: begin
        if (clk_match) begin
          state_d = S_CHECK;
          cnt_d   = CW'(1);
        end else begin
          slip_d = slip_inc;
        end
      end
      S_CHECK: begin
        if (clk_match) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(LOCK_COUNT)) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
            miss_d   = '0;
          end
        end else begin
          state_d = S_SEARCH;
          slip_d  = slip_inc;
          cnt_d   = '0;
        end
      end
      S_LOCKED: begin
        if (clk_match) begin
          miss_d = '0;
        end else if (miss_inc == MW'(LOSS_COUNT)) begin
          state_d  = S_SEARCH;
          locked_d = 1'b0;
          slip_d   = slip_inc;
          miss_d   = '0;
          cnt_d    = '0;
        end else begin
          miss_d = miss_inc;
        end
      end
      default: begin
        state_d  = S_SEARCH;
        slip_d   = '0;
        cnt_d    = '0;
        miss_d   = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  // Hold pixels back until lock has been stable long enough to flush the pipe.
  always_comb begin
    lkp_d   = {lkp_q[0], locked_q};
    data_ok = locked_q & lkp_q[0] & lkp_q[1];
  end

  // Decode aligned data lanes into sync, enable and expanded colour.
  always_comb begin
    dat_d = {algn[3], algn[2], algn[1]};
    hs_d  = 1'b1;
    vs_d  = 1'b1;
    de_d  = 1'b0;
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (data_ok) begin
      red_d = {dat_q[5:0], dat_q[5:4]};
      grn_d = {dat_q[11:7], dat_q[6], dat_q[11:10]};
      blu_d = {dat_q[17:14], dat_q[13:12], dat_q[17:16]};
      hs_d  = dat_q[18];
      vs_d  = dat_q[19];
      de_d  = dat_q[20];
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q    <= '0;
      prv_q    <= '0;
      state_q  <= S_SEARCH;
      slip_q   <= '0;
      cnt_q    <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      lkp_q    <= '0;
      dat_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
      red_q    <= '0;
      grn_q    <= '0;
      blu_q    <= '0;
    end else begin
      cur_q    <= cur_d;
      prv_q    <= prv_d;
      state_q  <= state_d;
      slip_q   <= slip_d;
      cnt_q    <= cnt_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      lkp_q    <= lkp_d;
      dat_q    <= dat_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      red_q    <= red_d;
      grn_q    <= grn_d;
      blu_q    <= blu_d;
    end
  end

`ifdef LVDS_RX_TIMING_EN
  logic [10:0] wcnt_q, wcnt_d;
  logic [10:0] lcnt_q, lcnt_d;
  logic [10:0] aw_q, aw_d;
  logic [10:0] ah_q, ah_d;
  logic        de_prev_q, de_prev_d;
  logic        vs_prev_q, vs_prev_d;

  // Measure enable width per line and enabled lines per frame; results load on falling edges.
  always_comb begin
    wcnt_d    = wcnt_q;
    lcnt_d    = lcnt_q;
    aw_d      = aw_q;
    ah_d      = ah_q;
    de_prev_d = de_q;
    vs_prev_d = vs_q;
    if (!locked_q) begin
      wcnt_d    = '0;
      lcnt_d    = '0;
      de_prev_d = 1'b0;
      vs_prev_d = 1'b1;
    end else begin
      if (de_q) begin
        wcnt_d = (wcnt_q == 11'd2047) ? wcnt_q : wcnt_q + 11'd1;
      end
      if (de_prev_q && !de_q) begin
        aw_d   = wcnt_q;
        wcnt_d = '0;
        lcnt_d = (lcnt_q == 11'd2047) ? lcnt_q : lcnt_q + 11'd1;
      end
      if (vs_prev_q && !vs_q) begin
        ah_d   = lcnt_d;
        lcnt_d = '0;
      end
    end
  end

  // Measurement registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q    <= '0;
      lcnt_q    <= '0;
      aw_q      <= '0;
      ah_q      <= '0;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b1;
    end else begin
      wcnt_q    <= wcnt_d;
      lcnt_q    <= lcnt_d;
      aw_q      <= aw_d;
      ah_q      <= ah_d;
      de_prev_q <= de_prev_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign ActiveWidth  = aw_q;
  assign ActiveHeight = ah_q;
`else
  assign ActiveWidth  = '0;
  assign ActiveHeight = '0;
`endif

  assign HSync      = hs_q;
  assign VSync      = vs_q;
  assign DataEnable = de_q;
  assign Red        = red_q;
  assign Green      = grn_q;
  assign Blue       = blu_q;
  assign locked     = locked_q;
  assign slip       = slip_q;

endmodule

// File: tb/tb_lvds_rx_decoder.sv
// tb_lvds_rx_decoder: drives a bit-offset serializer model into the decoder.
// It checks alignment, pixel decode, loss of lock, reset and measurement.
module tb_lvds_rx_decoder;

  localparam logic [6:0] CLK_GOOD = 7'b1100011;
  localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 24'h0};

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0]  clock_word, channel1_word, channel2_word, channel3_word;
  logic        HSync, VSync, DataEnable, locked;
  logic [7:0]  Red, Green, Blue;
  logic [2:0]  slip;
  logic [10:0] ActiveWidth, ActiveHeight;

  lvds_rx_decoder #(.LOCK_COUNT(16), .LOSS_COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .clock_word(clock_word), .channel1_word(channel1_word),
    .channel2_word(channel2_word), .channel3_word(channel3_word),
    .HSync(HSync), .VSync(VSync), .DataEnable(DataEnable),
    .Red(Red), .Green(Green), .Blue(Blue),
    .locked(locked), .slip(slip),
    .ActiveWidth(ActiveWidth), .ActiveHeight(ActiveHeight)
  );

  int checks = 0;
  int errors = 0;
  int off = 0;
  logic [6:0] prev_l [4];
  logic [26:0] exp_q[$];

  function automatic logic [26:0] obs();
    return {HSync, VSync, DataEnable, Red, Green, Blue};
  endfunction

  function automatic logic [26:0] exp_pix(input logic [5:0] r, g, b, input logic hs, vs, de);
    return {hs, vs, de, r, r[5:4], g, g[5:4], b, b[5:4]};
  endfunction

  // Serializer model: the logical stream is delayed by 'off' bits before word chunking.
  function automatic logic [6:0] ser(input logic [6:0] p, input logic [6:0] c, input int o);
    logic [13:0] v;
    v = {p, c} >> o;
    return v[6:0];
  endfunction

  // Driver tasks
  task automatic drive_words(input logic [6:0] lc, l1, l2, l3);
    clock_word    = ser(prev_l[0], lc, off);
    channel1_word = ser(prev_l[1], l1, off);
    channel2_word = ser(prev_l[2], l2, off);
    channel3_word = ser(prev_l[3], l3, off);
    prev_l[0] = lc; prev_l[1] = l1; prev_l[2] = l2; prev_l[3] = l3;
  endtask

  task automatic drive_pixel(input logic [6:0] lc, input logic [5:0] r, g, b, input logic hs, vs, de);
    drive_words(lc, {g[0], r}, {b[1:0], g[5:1]}, {de, vs, hs, b[5:2]});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_lock(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      drive_pixel(CLK_GOOD, 6'h3F, 6'h2A, 6'h15, 1'b0, 1'b0, 1'b1);
      tick();
      if (locked) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_pixel(CLK_GOOD, 6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b exp 0", locked); end
    checks++; if (slip !== 3'd0) begin errors++; $display("FAIL reset_slip got %0d exp 0", slip); end
    checks++; if (obs() !== IDLE) begin errors++; $display("FAIL reset_outputs got %0h exp %0h", obs(), IDLE); end
    checks++; if (ActiveWidth !== 11'd0) begin errors++; $display("FAIL reset_aw got %0d exp 0", ActiveWidth); end
    checks++; if (ActiveHeight !== 11'd0) begin errors++; $display("FAIL reset_ah got %0d exp 0", ActiveHeight); end
  endtask

  task automatic test_lock();
    int lock_n;
    int idle_bad;
    logic [26:0] px;
    lock_n = 0;
    idle_bad = 0;
    off = 3;
    rst = 1'b0;
    px = exp_pix(6'h3F, 6'h2A, 6'h15, 1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= 21; n++) begin
      drive_pixel(CLK_GOOD, 6'h3F, 6'h2A, 6'h15, 1'b0, 1'b0, 1'b1);
      tick();
      if (locked) begin lock_n = n; break; end
      if (obs() !== IDLE) idle_bad++;
    end
    checks++; if (lock_n == 0) begin errors++; $display("FAIL lock_time got unlocked exp locked within 21 cycles"); end
    checks++; if (slip !== 3'd3) begin errors++; $display("FAIL lock_slip got %0d exp 3", slip); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle_unlocked got %0d non-idle cycles exp 0", idle_bad); end
    // First valid pixel three cycles after lock rises.
    for (int k = 1; k <= 3; k++) begin
      drive_pixel(CLK_GOOD, 6'h3F, 6'h2A, 6'h15, 1'b0, 1'b0, 1'b1);
      tick();
      if (k < 3) begin
        checks++; if (obs() !== IDLE) begin errors++; $display("FAIL first_valid_early k=%0d got %0h exp %0h", k, obs(), IDLE); end
      end else begin
        checks++; if (obs() !== px) begin errors++; $display("FAIL first_valid got %0h exp %0h", obs(), px); end
      end
    end
  endtask

  task automatic test_pixel();
    logic [5:0] r, g, b;
    logic hs, vs, de;
    logic [26:0] e;
    exp_q.delete();
    for (int i = 0; i < 43; i++) begin
      if (i == 0) begin
        r = 6'h3F; g = 6'h00; b = 6'h15; hs = 1'b1; vs = 1'b1; de = 1'b1;
      end else begin
        r = 6'($urandom_range(0, 63)); g = 6'($urandom_range(0, 63)); b = 6'($urandom_range(0, 63));
        hs = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1)); de = 1'($urandom_range(0, 1));
      end
      drive_pixel(CLK_GOOD, r, g, b, hs, vs, de);
      exp_q.push_back(exp_pix(r, g, b, hs, vs, de));
      tick();
      if (exp_q.size() > 3) begin
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL pixel i=%0d got %0h exp %0h", i, obs(), e); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_loss();
    int drop_n;
    int stay_bad;
    stay_bad = 0;
    drop_n = 0;
    for (int k = 0; k < 3; k++) begin
      drive_pixel(7'h00, 6'h3F, 6'h01, 6'h01, 1'b0, 1'b1, 1'b1);
      tick();
      if (!locked) stay_bad++;
    end
    for (int k = 0; k < 8; k++) begin
      drive_pixel(CLK_GOOD, 6'h3F, 6'h01, 6'h01, 1'b0, 1'b1, 1'b1);
      tick();
      if (!locked) stay_bad++;
    end
    checks++; if (stay_bad != 0) begin errors++; $display("FAIL loss_3bad got %0d unlocked cycles exp 0", stay_bad); end
    for (int k = 0; k < 4; k++) begin
      drive_pixel(7'h00, 6'h3F, 6'h01, 6'h01, 1'b0, 1'b1, 1'b1);
      tick();
    end
    for (int k = 1; k <= 8; k++) begin
      if (!locked) begin drop_n = k; break; end
      drive_pixel(CLK_GOOD, 6'h3F, 6'h01, 6'h01, 1'b0, 1'b1, 1'b1);
      tick();
    end
    checks++; if (drop_n == 0) begin errors++; $display("FAIL loss_4bad got locked exp unlocked within 8 cycles"); end
    drive_pixel(CLK_GOOD, 6'h3F, 6'h01, 6'h01, 1'b0, 1'b1, 1'b1);
    tick();
    checks++; if (obs() !== IDLE) begin errors++; $display("FAIL loss_idle got %0h exp %0h", obs(), IDLE); end
  endtask

  task automatic test_reset_mid_lock();
    bit ok;
    wait_lock(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL relock got unlocked exp locked within 40 cycles"); end
    for (int k = 0; k < 4; k++) begin
      drive_pixel(CLK_GOOD, 6'h3F, 6'h2A, 6'h15, 1'b0, 1'b0, 1'b1);
      tick();
    end
    checks++; if (Red !== 8'hFF) begin errors++; $display("FAIL pre_reset_red got %0h exp ff", Red); end
    rst = 1'b1;
    drive_pixel(CLK_GOOD, 6'h3F, 6'h2A, 6'h15, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midrst_locked got %0b exp 0", locked); end
    checks++; if (slip !== 3'd0) begin errors++; $display("FAIL midrst_slip got %0d exp 0", slip); end
    checks++; if (Red !== 8'h00) begin errors++; $display("FAIL midrst_red got %0h exp 0", Red); end
    checks++; if (HSync !== 1'b1) begin errors++; $display("FAIL midrst_hsync got %0b exp 1", HSync); end
  endtask

  task automatic test_slip_wrap();
    bit seen;
    rst = 1'b1;
    drive_pixel(CLK_GOOD, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0);
    tick();
    off = 6;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive_pixel(CLK_GOOD, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0);
      tick();
      if (slip == 3'd6) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL wrap_reach6 got %0d exp 6", slip); end
    for (int k = 0; k < 3; k++) begin
      drive_pixel(CLK_GOOD, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    checks++; if (slip !== 3'd6 || locked !== 1'b0) begin errors++; $display("FAIL wrap_check got slip %0d locked %0b exp slip 6 locked 0", slip, locked); end
    drive_pixel(7'h00, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0);
    tick();
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (slip == 3'd0) begin seen = 1'b1; break; end
      drive_pixel(CLK_GOOD, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    checks++; if (!seen || locked !== 1'b0) begin errors++; $display("FAIL wrap_to0 got slip %0d locked %0b exp slip 0 locked 0", slip, locked); end
    drive_pixel(CLK_GOOD, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if (slip !== 3'd1) begin errors++; $display("FAIL wrap_search got slip %0d exp 1", slip); end
  endtask

  task automatic test_timing();
`ifdef LVDS_RX_TIMING_EN
    localparam int W = 20, HB = 5, H = 6, VB = 3;
    bit ok;
    logic hs, vs, de;
    rst = 1'b1;
    drive_pixel(CLK_GOOD, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0);
    tick();
    off = 2;
    rst = 1'b0;
    wait_lock(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timing_lock got unlocked exp locked"); end
    for (int k = 0; k < 6; k++) begin
      drive_pixel(CLK_GOOD, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    for (int f = 0; f < 2; f++) begin
      for (int ln = 0; ln < H + VB; ln++) begin
        for (int px = 0; px < W + HB; px++) begin
          de = (ln < H) && (px < W);
          vs = (ln != H);
          hs = !((px >= W + 1) && (px < W + 3));
          drive_pixel(CLK_GOOD, 6'h11, 6'h22, 6'h33, hs, vs, de);
          tick();
          if (f == 0 && ln == 0 && px == W + HB - 1) begin
            checks++; if (ActiveWidth !== 11'(W)) begin errors++; $display("FAIL timing_width got %0d exp %0d", ActiveWidth, W); end
          end
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive_pixel(CLK_GOOD, 6'h0, 6'h0, 6'h0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    checks++; if (ActiveHeight !== 11'(H)) begin errors++; $display("FAIL timing_height got %0d exp %0d", ActiveHeight, H); end
`else
    // Without measurement, traffic with enable toggling must leave both at zero.
    for (int k = 0; k < 30; k++) begin
      drive_pixel(CLK_GOOD, 6'h3F, 6'h3F, 6'h3F, 1'($urandom_range(0, 1)), 1'(k % 10 != 0), 1'(k % 3 != 0));
      tick();
    end
    checks++; if (ActiveWidth !== 11'd0) begin errors++; $display("FAIL timing_off_aw got %0d exp 0", ActiveWidth); end
    checks++; if (ActiveHeight !== 11'd0) begin errors++; $display("FAIL timing_off_ah got %0d exp 0", ActiveHeight); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    for (int l = 0; l < 4; l++) prev_l[l] = '0;
    drive_words('0, '0, '0, '0);
    @(negedge clk);
    test_reset();
    test_lock();
    test_pixel();
    test_loss();
    test_reset_mid_lock();
    test_slip_wrap();
    test_timing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
